erx_mux3: RTL and testbench
===========================

ERX_MUX3 -- requirements
Module: erx_mux3

Interface
REQ-001 PW, 104, packet width of every input and output packet bus.
REQ-002 CW, 16, width of the accepted-packet counter.
REQ-003 clk  input  1  single clock (system side of the receive FIFOs); all logic on rising edge.
REQ-004 nreset  input  1  reset, synchronous and active-low.
REQ-005 rxwr_access / rxwr_packet  input  1 / PW  write-request stream from the receive FIFO.
REQ-006 rxwr_wait  output  1  pushback to the write source.
REQ-007 rxrd_access / rxrd_packet  input  1 / PW  read-request stream.
REQ-008 rxrd_wait  output  1  pushback to the read-request source.
REQ-009 rxrr_access / rxrr_packet  input  1 / PW  read-response stream.
REQ-010 rxrr_wait  output  1  pushback to the read-response source.
REQ-011 mux_access  output  1  merged stream valid.
REQ-012 mux_packet  output  PW  merged stream packet.
REQ-013 mux_src  output  2  origin of the current output: 0=rr, 1=wr, 2=rd, 3=unused.
REQ-014 mux_wait  input  1  pushback from the downstream consumer.
REQ-015 mux_count  output  CW  count of packets accepted into the output register.

Function
REQ-016 Handshake: a source holds access and packet stable while its wait is high; a packet transfers on a cycle where access=1 and wait=0.
REQ-017 Output stage: a single register (mux_access, mux_packet, mux_src); it is "free" when mux_access=0 or mux_wait=0.
REQ-018 When free and at least one input is requesting, the granted input's packet loads into the output register on the next clk edge: latency exactly 1 cycle.
REQ-019 When free and no input is requesting, mux_access clears on the next edge; mux_packet and mux_src hold.
REQ-020 When not free (mux_access=1, mux_wait=1), the output register holds and all three wait outputs are 1.
REQ-021 Waits are combinational: a requesting input's wait=0 only if it is granted and the stage is free; all non-granted inputs see wait=1.
REQ-022 A non-requesting input's wait SHALL equal 1 whenever the stage is not free, else 0.
REQ-023 Grant is one-hot among requesting inputs; never two transfers in one cycle.
REQ-024 Fixed-priority order (default): rr > wr > rd.
REQ-025 mux_count increments by 1 per accepted transfer, wraps from 2^CW-1 to 0.
REQ-026 Simultaneous output drain and input accept in the same cycle SHALL sustain one packet per cycle with no bubble.

Reset
REQ-027 On a clk edge with nreset=0: mux_access=0, mux_packet=0, mux_src=0, mux_count=0, round-robin pointer=0 (rr).
REQ-028 During reset all wait outputs SHALL be 1; no input is accepted.
REQ-029 Reset mid-transfer discards the held output packet; first post-reset grant follows REQ-024 or REQ-031.

Configuration
REQ-030 Macro ERX_MUX_RR_EN selects the arbitration policy.
REQ-031 With ERX_MUX_RR_EN defined: round-robin; after a grant to source i, priority order restarts at (i+1) mod 3 over rr,wr,rd; pointer advances only on an accepted transfer.
REQ-032 Without ERX_MUX_RR_EN: fixed priority per REQ-024, no pointer register.

Verification
REQ-033 Reset: nreset=0 for 2 cycles with all accesses=1 -> mux_access=0, mux_count=0, all waits=1.
REQ-034 Single source: rxwr_access=1, packet=0xA5 (zero-extended), mux_wait=0 -> next cycle mux_access=1, mux_packet=0xA5, mux_src=1, mux_count=1.
REQ-035 Contention, fixed priority: all three access=1 for 4 cycles -> mux_src=0 every cycle, rxwr_wait=rxrd_wait=1, mux_count=4.
REQ-036 Contention, ERX_MUX_RR_EN: all three access=1 for 6 cycles -> mux_src sequence 0,1,2,0,1,2.
REQ-037 Backpressure: mux_wait=1 for 3 cycles with packet held -> mux_packet unchanged, all waits=1, count frozen; mux_wait=0 -> next packet loads next cycle, no bubble.
REQ-038 Wrap: preload traffic to mux_count=0xFFFF, one more transfer -> mux_count=0x0000.

Source files
------------

// File: rtl/erx_mux3.sv
// ============================================================================
// Module      : erx_mux3
// Description : Three-way receive-stream merger (rr / wr / rd) into a single
//               registered output stage with valid/wait handshaking and an
//               accepted-packet counter. Arbitration is fixed priority
//               (rr > wr > rd) unless ERX_MUX_RR_EN is defined, which enables
//               round-robin arbitration over rr, wr, rd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module erx_mux3 #(
  parameter int PW = 104,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          rxwr_access,
  input  logic [PW-1:0] rxwr_packet,
  output logic          rxwr_wait,
  input  logic          rxrd_access,
  input  logic [PW-1:0] rxrd_packet,
  output logic          rxrd_wait,
  input  logic          rxrr_access,
  input  logic [PW-1:0] rxrr_packet,
  output logic          rxrr_wait,
  output logic          mux_access,
  output logic [PW-1:0] mux_packet,
  output logic [1:0]    mux_src,
  input  logic          mux_wait,
  output logic [CW-1:0] mux_count
);

  // Source codes double as bit positions in the request vector.
  localparam logic [1:0] c_src_rr = 2'd0;
  localparam logic [1:0] c_src_wr = 2'd1;
  localparam logic [1:0] c_src_rd = 2'd2;

  logic          r_mux_access;
  logic [PW-1:0] r_mux_packet;
  logic [1:0]    r_mux_src;
  logic [CW-1:0] r_mux_count;

  logic [2:0]    w_req;
  logic          w_any;
  logic          w_free;
  logic          w_accept;
  logic [1:0]    w_grant_src;
  logic [PW-1:0] w_grant_packet;

  assign w_req    = {rxrd_access, rxwr_access, rxrr_access};
  assign w_any    = |w_req;
  // The output register can take a new packet when empty or being drained.
  assign w_free   = ~r_mux_access | ~mux_wait;
  assign w_accept = nreset & w_free & w_any;

`ifdef ERX_MUX_RR_EN
  logic [1:0] r_ptr;
  logic [2:0] w_rot;
  logic [1:0] w_off;
  logic [2:0] w_sum;

  // Rotate requests so the pointer's source is bit 0, take the first set bit, rotate back.
  always_comb begin
    case (r_ptr)
      c_src_wr: w_rot = {w_req[0], w_req[2:1]};
      c_src_rd: w_rot = {w_req[1:0], w_req[2]};
      default:  w_rot = w_req;
    endcase
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else               w_off = 2'd2;
    w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
    w_grant_src = (w_sum >= 3'd3) ? (w_sum[1:0] - 2'd3) : w_sum[1:0];
  end

  // Move the pointer just past the source that actually transferred.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_ptr <= c_src_rr;
    end else if (w_accept) begin
      r_ptr <= (w_grant_src == c_src_rd) ? c_src_rr : (w_grant_src + 2'd1);
    end
  end
`else
  // Fixed priority: read responses first, then writes, then read requests.
  always_comb begin
    if (rxrr_access)      w_grant_src = c_src_rr;
    else if (rxwr_access) w_grant_src = c_src_wr;
    else                  w_grant_src = c_src_rd;
  end
`endif

  // Select the packet of the granted source.
  always_comb begin
    case (w_grant_src)
      c_src_wr: w_grant_packet = rxwr_packet;
      c_src_rd: w_grant_packet = rxrd_packet;
      default:  w_grant_packet = rxrr_packet;
    endcase
  end

  // A requester proceeds only when granted into a free stage; idle sources
  // still see the stage's busy state, and everything stalls in reset.
  assign rxrr_wait = ~nreset | ~w_free | (rxrr_access & (w_grant_src != c_src_rr));
  assign rxwr_wait = ~nreset | ~w_free | (rxwr_access & (w_grant_src != c_src_wr));
  assign rxrd_wait = ~nreset | ~w_free | (rxrd_access & (w_grant_src != c_src_rd));

  // Output register: load on accept, clear valid when free and idle, hold when stalled.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_mux_access <= 1'b0;
      r_mux_packet <= '0;
      r_mux_src    <= c_src_rr;
      r_mux_count  <= '0;
    end else if (w_free) begin
      if (w_any) begin
        r_mux_access <= 1'b1;
        r_mux_packet <= w_grant_packet;
        r_mux_src    <= w_grant_src;
        r_mux_count  <= r_mux_count + CW'(1);
      end else begin
        r_mux_access <= 1'b0;
      end
    end
  end

  assign mux_access = r_mux_access;
  assign mux_packet = r_mux_packet;
  assign mux_src    = r_mux_src;
  assign mux_count  = r_mux_count;

endmodule

`default_nettype wire

// File: tb/tb_erx_mux3.sv
// ============================================================================
// Module      : tb_erx_mux3
// Description : Self-checking bench for erx_mux3 with a behavioural reference
//               model, directed scenarios and randomized traffic. Honours
//               ERX_MUX_RR_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_erx_mux3;

  localparam int PW = 104;
  localparam int CW = 16;

  logic          clk;
  logic          nreset;
  logic          mux_wait_d;
  logic          acc [3];
  logic [PW-1:0] pkt [3];

  logic          rxwr_wait, rxrd_wait, rxrr_wait;
  logic          mux_access;
  logic [PW-1:0] mux_packet;
  logic [1:0]    mux_src;
  logic [CW-1:0] mux_count;

  // Reference model state (index 0=rr, 1=wr, 2=rd)
  logic          m_acc;
  logic [PW-1:0] m_pkt;
  logic [1:0]    m_src;
  logic [CW-1:0] m_cnt;
  int            m_ptr;
  logic          last_xfer [3];

  int checks;
  int failures;

  erx_mux3 #(.PW(PW), .CW(CW)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .rxwr_access (acc[1]),
    .rxwr_packet (pkt[1]),
    .rxwr_wait   (rxwr_wait),
    .rxrd_access (acc[2]),
    .rxrd_packet (pkt[2]),
    .rxrd_wait   (rxrd_wait),
    .rxrr_access (acc[0]),
    .rxrr_packet (pkt[0]),
    .rxrr_wait   (rxrr_wait),
    .mux_access  (mux_access),
    .mux_packet  (mux_packet),
    .mux_src     (mux_src),
    .mux_wait    (mux_wait_d),
    .mux_count   (mux_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // One clock: check waits against the model, clock, update model, check outputs.
  task automatic step();
    logic free;
    int   g;
    int   base;
    logic ew [3];
    logic dw [3];
    #1;
    free = !m_acc || !mux_wait_d;
`ifdef ERX_MUX_RR_EN
    base = m_ptr;
`else
    base = 0;
`endif
    g = -1;
    if (nreset) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && acc[(base + k) % 3]) g = (base + k) % 3;
      end
    end
    dw[0] = rxrr_wait;
    dw[1] = rxwr_wait;
    dw[2] = rxrd_wait;
    for (int i = 0; i < 3; i++) begin
      ew[i] = !nreset || !free || (acc[i] && g != i);
      last_xfer[i] = acc[i] && !ew[i];
    end
    chk("wait_rr", dw[0], ew[0]);
    chk("wait_wr", dw[1], ew[1]);
    chk("wait_rd", dw[2], ew[2]);
    @(posedge clk);
    if (!nreset) begin
      m_acc = 1'b0;
      m_pkt = '0;
      m_src = 2'd0;
      m_cnt = '0;
      m_ptr = 0;
    end else if (free) begin
      if (g >= 0) begin
        m_acc = 1'b1;
        m_pkt = pkt[g];
        m_src = 2'(g);
        m_cnt = m_cnt + 1'b1;
        m_ptr = (g + 1) % 3;
      end else begin
        m_acc = 1'b0;
      end
    end
    #1;
    chk("mux_access", mux_access, m_acc);
    chk("mux_packet", mux_packet, m_pkt);
    chk("mux_src", mux_src, m_src);
    chk("mux_count", mux_count, m_cnt);
  endtask

  task automatic set_acc(input logic a0, input logic a1, input logic a2);
    acc[0] = a0;
    acc[1] = a1;
    acc[2] = a2;
  endtask

  initial begin
    int            n_cont;
    int            eg;
    logic [PW-1:0] hold_pkt;
    logic [CW-1:0] hold_cnt;

    checks   = 0;
    failures = 0;
    m_acc = 1'b0; m_pkt = '0; m_src = 2'd0; m_cnt = '0; m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      pkt[i] = rnd_pkt();
      last_xfer[i] = 1'b0;
    end
    mux_wait_d = 1'b0;

    // Reset with every source requesting
    nreset = 1'b0;
    set_acc(1'b1, 1'b1, 1'b1);
    step();
    step();
    chk("rst_access", mux_access, 1'b0);
    chk("rst_count", mux_count, 16'h0000);
    chk("rst_packet", mux_packet, 0);
    #1;
    chk("rst_waits", {rxrr_wait, rxwr_wait, rxrd_wait}, 3'b111);

    // Single write source
    nreset = 1'b1;
    set_acc(1'b0, 1'b1, 1'b0);
    pkt[1] = PW'(8'hA5);
    step();
    chk("single_access", mux_access, 1'b1);
    chk("single_packet", mux_packet, 8'hA5);
    chk("single_src", mux_src, 2'd1);
    chk("single_count", mux_count, 16'h0001);
    set_acc(1'b0, 1'b0, 1'b0);
    step();
    chk("idle_access", mux_access, 1'b0);
    chk("idle_packet_hold", mux_packet, 8'hA5);

    // Contention from a fresh reset
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    set_acc(1'b1, 1'b1, 1'b1);
`ifdef ERX_MUX_RR_EN
    n_cont = 6;
`else
    n_cont = 4;
`endif
    for (int c = 0; c < n_cont; c++) begin
`ifdef ERX_MUX_RR_EN
      eg = c % 3;
`else
      eg = 0;
`endif
      #1;
      chk("cont_wait_rr", rxrr_wait, eg != 0);
      chk("cont_wait_wr", rxwr_wait, eg != 1);
      chk("cont_wait_rd", rxrd_wait, eg != 2);
      step();
      chk("cont_src", mux_src, 2'(eg));
      for (int i = 0; i < 3; i++) if (last_xfer[i]) pkt[i] = rnd_pkt();
    end
    chk("cont_count", mux_count, 16'(n_cont));

    // Backpressure: stage full and stalled for three cycles
    mux_wait_d = 1'b1;
    hold_pkt = mux_packet;
    hold_cnt = mux_count;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_waits", {rxrr_wait, rxwr_wait, rxrd_wait}, 3'b111);
      step();
      chk("bp_packet", mux_packet, hold_pkt);
      chk("bp_count", mux_count, hold_cnt);
      chk("bp_access", mux_access, 1'b1);
    end
    // Release: pointer (if any) is back at rr, so rr wins in both builds
    mux_wait_d = 1'b0;
    hold_pkt = pkt[0];
    step();
    chk("bp_release_packet", mux_packet, hold_pkt);
    chk("bp_release_count", mux_count, hold_cnt + 16'd1);
    for (int i = 0; i < 3; i++) if (last_xfer[i]) pkt[i] = rnd_pkt();
    step();
    chk("bp_nobubble_count", mux_count, hold_cnt + 16'd2);
    chk("bp_nobubble_access", mux_access, 1'b1);

    // Randomized traffic with handshake-respecting sources
    for (int c = 0; c < 2000; c++) begin
      nreset     = ($urandom_range(99) >= 2);
      mux_wait_d = ($urandom_range(99) < 30);
      for (int i = 0; i < 3; i++) begin
        if (!(acc[i] && !last_xfer[i])) begin
          acc[i] = ($urandom_range(99) < 60);
          pkt[i] = rnd_pkt();
        end
      end
      step();
    end

    // Counter wrap: a single continuous stream
    nreset = 1'b0;
    mux_wait_d = 1'b0;
    set_acc(1'b0, 1'b0, 1'b0);
    step();
    nreset = 1'b1;
    set_acc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 65535; c++) begin
      if ((c & 1023) == 0) pkt[0] = rnd_pkt();
      step();
    end
    chk("wrap_preload", mux_count, 16'hFFFF);
    step();
    chk("wrap_zero", mux_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
